mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback formatter for the pipelined CPU. It captures the memory-stage result each cycle, performs load byte/halfword selection and extension, and selects the writeback source. It then drives the register file write port (RegWrite, Write_register, Write_data) one cycle later. It also reports misaligned loads and counts retired instructions.

---
 rtl/mem_wb_if.sv | 33 +++
 rtl/mem_wb_stage.sv | 126 ++++++++++++
 tb/tb_mem_wb_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// MEM-to-WB bundle: memory-stage result in, register-file write port and status out.
interface mem_wb_if;
  logic        stall;
  logic        mem_valid;
  logic        mem_RegWrite;
  logic [1:0]  mem_MemtoReg;
  logic [2:0]  mem_LoadType;
  logic [4:0]  mem_Write_register;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] mem_pc_plus4;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        wb_valid;
  logic        misalign_err;
  logic [31:0] err_addr;
  logic [31:0] retire_count;

  modport master (
    output stall, mem_valid, mem_RegWrite, mem_MemtoReg, mem_LoadType,
           mem_Write_register, mem_alu_result, mem_read_data, mem_pc_plus4,
    input  RegWrite, Write_register, Write_data, wb_valid, misalign_err,
           err_addr, retire_count
  );

  modport slave (
    input  stall, mem_valid, mem_RegWrite, mem_MemtoReg, mem_LoadType,
           mem_Write_register, mem_alu_result, mem_read_data, mem_pc_plus4,
    output RegWrite, Write_register, Write_data, wb_valid, misalign_err,
           err_addr, retire_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction/extension, writeback select,
// misaligned-load reporting and retire counting, all outputs registered.
module mem_wb_stage (
  input  logic     clk,
  input  logic     reset,
  mem_wb_if.slave  bus
);

  function automatic logic [31:0] fmt_load(input logic [2:0] lt, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (lt)
      3'b001:  r = {{24{b[7]}}, b};
      3'b010:  r = {24'd0, b};
      3'b011:  r = {{16{h[15]}}, h};
      3'b100:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] a);
    logic m;
    case (lt)
      3'b001, 3'b010: m = 1'b0;
      3'b011, 3'b100: m = a[0];
      default:        m = (a != 2'b00);
    endcase
    return m;
  endfunction

  logic        bubble_s;
  logic        misalign_s;
  logic [31:0] wb_src_s;

  logic        reg_write_d,      reg_write_q;
  logic [4:0]  write_register_d, write_register_q;
  logic [31:0] write_data_d,     write_data_q;
  logic        wb_valid_d,       wb_valid_q;
  logic        misalign_err_d,   misalign_err_q;
  logic [31:0] err_addr_d,       err_addr_q;
  logic [31:0] retire_count_d,   retire_count_q;

  // Writeback source selection; the reserved encoding falls back to the ALU result.
  always_comb begin
    bubble_s   = bus.stall | ~bus.mem_valid;
    misalign_s = (bus.mem_MemtoReg == 2'd1) &
                 is_misaligned(bus.mem_LoadType, bus.mem_alu_result[1:0]);
    case (bus.mem_MemtoReg)
      2'd1:    wb_src_s = fmt_load(bus.mem_LoadType, bus.mem_alu_result[1:0], bus.mem_read_data);
      2'd2:    wb_src_s = bus.mem_pc_plus4;
      default: wb_src_s = bus.mem_alu_result;
    endcase
  end

  // Next WB contents; write index/data are zeroed whenever no write happens.
  always_comb begin
    reg_write_d      = 1'b0;
    write_register_d = 5'd0;
    write_data_d     = 32'd0;
    wb_valid_d       = 1'b0;
    misalign_err_d   = 1'b0;
    err_addr_d       = err_addr_q;
    retire_count_d   = retire_count_q;
    if (!bubble_s) begin
      wb_valid_d     = 1'b1;
      misalign_err_d = misalign_s;
      retire_count_d = retire_count_q + 32'd1;
      reg_write_d    = bus.mem_RegWrite & ~misalign_s & (bus.mem_Write_register != 5'd0);
      if (reg_write_d) begin
        write_register_d = bus.mem_Write_register;
        write_data_d     = wb_src_s;
      end else begin
        write_register_d = 5'd0;
        write_data_d     = 32'd0;
      end
      if (misalign_s) begin
        err_addr_d = bus.mem_alu_result;
      end else begin
        err_addr_d = err_addr_q;
      end
    end else begin
      wb_valid_d = 1'b0;
    end
  end

  // WB register bank, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q      <= 1'b0;
      write_register_q <= 5'd0;
      write_data_q     <= 32'd0;
      wb_valid_q       <= 1'b0;
      misalign_err_q   <= 1'b0;
      err_addr_q       <= 32'd0;
      retire_count_q   <= 32'd0;
    end else begin
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      wb_valid_q       <= wb_valid_d;
      misalign_err_q   <= misalign_err_d;
      err_addr_q       <= err_addr_d;
      retire_count_q   <= retire_count_d;
    end
  end

  assign bus.RegWrite       = reg_write_q;
  assign bus.Write_register = write_register_q;
  assign bus.Write_data     = write_data_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.misalign_err   = misalign_err_q;
  assign bus.err_addr       = err_addr_q;
  assign bus.retire_count   = retire_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a behavioural model checked every cycle,
// plus hand-computed expectations for the documented cases.
module tb_mem_wb_stage;
  logic clk;
  logic reset;
  mem_wb_if bif ();

  mem_wb_stage dut (.clk(clk), .reset(reset), .bus(bif));

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_rw  = 1'b0;
  logic [4:0]  m_wr  = 5'd0;
  logic [31:0] m_wd  = 32'd0;
  logic        m_v   = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] m_ea  = 32'd0;
  logic [31:0] m_cnt = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a load/ALU/link produces, derived from shifts and masks.
  function automatic logic [31:0] model_value(input logic [1:0] mtr, input logic [2:0] lt,
                                              input logic [31:0] addr, input logic [31:0] w,
                                              input logic [31:0] pc);
    int unsigned off;
    logic [31:0] v;
    off = addr % 4;
    if (mtr == 2'd2) return pc;
    if (mtr != 2'd1) return addr;
    if (lt == 3'd1 || lt == 3'd2) begin
      v = (w >> (8 * off)) & 32'h0000_00FF;
      if (lt == 3'd1 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (lt == 3'd3 || lt == 3'd4) begin
      v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (lt == 3'd3 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic model_mis(input logic [1:0] mtr, input logic [2:0] lt,
                                     input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (mtr != 2'd1) return 1'b0;
    if (lt == 3'd1 || lt == 3'd2) return 1'b0;
    if (lt == 3'd3 || lt == 3'd4) return (off % 2) != 0;
    return off != 0;
  endfunction

  // Model update from the inputs present at each capture edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rw <= 1'b0; m_wr <= 5'd0; m_wd <= 32'd0; m_v <= 1'b0;
      m_mis <= 1'b0; m_ea <= 32'd0; m_cnt <= 32'd0;
    end else if (bif.stall || !bif.mem_valid) begin
      m_rw <= 1'b0; m_wr <= 5'd0; m_wd <= 32'd0; m_v <= 1'b0; m_mis <= 1'b0;
    end else begin
      automatic logic mis = model_mis(bif.mem_MemtoReg, bif.mem_LoadType, bif.mem_alu_result);
      automatic logic wr  = bif.mem_RegWrite && !mis && bif.mem_Write_register != 5'd0;
      m_v   <= 1'b1;
      m_mis <= mis;
      m_rw  <= wr;
      m_wr  <= wr ? bif.mem_Write_register : 5'd0;
      m_wd  <= wr ? model_value(bif.mem_MemtoReg, bif.mem_LoadType, bif.mem_alu_result,
                                bif.mem_read_data, bif.mem_pc_plus4) : 32'd0;
      m_cnt <= m_cnt + 32'd1;
      if (mis) m_ea <= bif.mem_alu_result;
    end
  end

  // Every-cycle comparison against the model, away from the capture edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("m_RegWrite",       {31'd0, bif.RegWrite},       {31'd0, m_rw});
      chk("m_Write_register", {27'd0, bif.Write_register}, {27'd0, m_wr});
      chk("m_Write_data",     bif.Write_data,              m_wd);
      chk("m_wb_valid",       {31'd0, bif.wb_valid},       {31'd0, m_v});
      chk("m_misalign_err",   {31'd0, bif.misalign_err},   {31'd0, m_mis});
      chk("m_err_addr",       bif.err_addr,                m_ea);
      chk("m_retire_count",   bif.retire_count,            m_cnt);
    end
  end

  task automatic issue(input logic st, input logic v, input logic rw, input logic [1:0] mtr,
                       input logic [2:0] lt, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc);
    bif.stall = st; bif.mem_valid = v; bif.mem_RegWrite = rw; bif.mem_MemtoReg = mtr;
    bif.mem_LoadType = lt; bif.mem_Write_register = rd; bif.mem_alu_result = alu;
    bif.mem_read_data = rdata; bif.mem_pc_plus4 = pc;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_RegWrite"},  {31'd0, bif.RegWrite},       32'd0);
    chk({tag, "_wr"},        {27'd0, bif.Write_register}, 32'd0);
    chk({tag, "_wd"},        bif.Write_data,              32'd0);
    chk({tag, "_wb_valid"},  {31'd0, bif.wb_valid},       32'd0);
    chk({tag, "_misalign"},  {31'd0, bif.misalign_err},   32'd0);
    chk({tag, "_err_addr"},  bif.err_addr,                32'd0);
    chk({tag, "_retire"},    bif.retire_count,            32'd0);
  endtask

  logic [31:0] base;

  initial begin
    reset = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    chk_zero("rst");
    #2 reset = 1'b1;

    // Loads from 0x80FF1234
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd1, 5'd5, 32'h0000_1003, 32'h80FF_1234, 32'd0);
    chk("lb_rw", {31'd0, bif.RegWrite}, 32'd1);
    chk("lb_wr", {27'd0, bif.Write_register}, 32'd5);
    chk("lb_wd", bif.Write_data, 32'hFFFF_FF80);
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd2, 5'd5, 32'h0000_1003, 32'h80FF_1234, 32'd0);
    chk("lbu_wd", bif.Write_data, 32'h0000_0080);
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd4, 5'd6, 32'h0000_1002, 32'h80FF_1234, 32'd0);
    chk("lhu_wd", bif.Write_data, 32'h0000_80FF);
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd3, 5'd6, 32'h0000_1002, 32'h80FF_1234, 32'd0);
    chk("lh_wd", bif.Write_data, 32'hFFFF_80FF);
    chk("cnt4", bif.retire_count, 32'd4);

    // Misaligned lw
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd0, 5'd7, 32'h0000_1002, 32'h80FF_1234, 32'd0);
    chk("mis_rw", {31'd0, bif.RegWrite}, 32'd0);
    chk("mis_wd", bif.Write_data, 32'd0);
    chk("mis_err", {31'd0, bif.misalign_err}, 32'd1);
    chk("mis_addr", bif.err_addr, 32'h0000_1002);
    chk("mis_cnt", bif.retire_count, 32'd5);

    // Write to r0 is suppressed but retires
    issue(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
    chk("r0_rw", {31'd0, bif.RegWrite}, 32'd0);
    chk("r0_wd", bif.Write_data, 32'd0);
    chk("r0_valid", {31'd0, bif.wb_valid}, 32'd1);
    chk("r0_err_pulse", {31'd0, bif.misalign_err}, 32'd0);
    chk("r0_err_sticky", bif.err_addr, 32'h0000_1002);

    // jal then three stalled cycles, then the held instruction
    base = m_cnt;
    issue(1'b0, 1'b1, 1'b1, 2'd2, 3'd0, 5'd31, 32'h0000_0040, 32'd0, 32'h0040_0008);
    chk("jal_wr", {27'd0, bif.Write_register}, 32'd31);
    chk("jal_wd", bif.Write_data, 32'h0040_0008);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 5'd7, 32'h0000_1111, 32'd0, 32'd0);
      chk("stall_rw", {31'd0, bif.RegWrite}, 32'd0);
      chk("stall_valid", {31'd0, bif.wb_valid}, 32'd0);
    end
    chk("stall_cnt", bif.retire_count, base + 32'd1);
    issue(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 5'd7, 32'h0000_1111, 32'd0, 32'd0);
    chk("unstall_wd", bif.Write_data, 32'h0000_1111);
    chk("unstall_cnt", bif.retire_count, base + 32'd2);

    // Back-to-back to r9, a bubble, further load variants
    issue(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 5'd9, 32'h0000_000A, 32'd0, 32'd0);
    chk("b2b1", bif.Write_data, 32'h0000_000A);
    issue(1'b0, 1'b1, 1'b1, 2'd3, 3'd0, 5'd9, 32'h0000_000B, 32'd0, 32'd0);
    chk("b2b2_rsvd", bif.Write_data, 32'h0000_000B);
    issue(1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 5'd3, 32'h0000_0033, 32'd0, 32'd0);
    chk("inval_rw", {31'd0, bif.RegWrite}, 32'd0);
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd3, 5'd8, 32'h0000_2001, 32'h80FF_1234, 32'd0);
    chk("lh_mis_addr", bif.err_addr, 32'h0000_2001);
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd1, 5'd8, 32'h0000_2001, 32'h80FF_1234, 32'd0);
    chk("lb_a1", bif.Write_data, 32'h0000_0012);
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd6, 5'd8, 32'h0000_3000, 32'h1234_5678, 32'd0);
    chk("lt6_word", bif.Write_data, 32'h1234_5678);
    issue(1'b0, 1'b1, 1'b1, 2'd1, 3'd6, 5'd8, 32'h0000_3002, 32'h1234_5678, 32'd0);
    chk("lt6_mis", {31'd0, bif.misalign_err}, 32'd1);

    // Clear, retire seven, then reset with a write on the port
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    for (int i = 1; i <= 7; i++)
      issue(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 5'd4, i, 32'd0, 32'd0);
    chk("pre_rst_cnt", bif.retire_count, 32'd7);
    chk("pre_rst_rw", {31'd0, bif.RegWrite}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    chk_zero("held_rst");
    reset = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 5'd6, 32'h0000_0055, 32'd0, 32'd0);
    chk("post_rst_cnt", bif.retire_count, 32'd1);
    chk("post_rst_wr", {27'd0, bif.Write_register}, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
